// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped tagged BTB of saturating counters with an
// optional gshare global history. Prediction is combinational from IF_PC;
// resolved branches from EX update the table, history and statistics.
module branch_predictor #(
   parameter int WORD_SIZE  = 16,
   parameter int INDEX_BITS = 4,
   parameter int CTR_BITS   = 2,
   parameter int HIST_BITS  = 0
) (
   input  logic                  Clk,
   input  logic                  Reset_N,
   input  logic                  Stall,
   input  logic [WORD_SIZE-1:0]  IF_PC,
   output logic                  pred_taken,
   output logic [WORD_SIZE-1:0]  pred_next,
   output logic [INDEX_BITS-1:0] pred_index,
   input  logic                  upd_valid,
   input  logic                  upd_is_cond,
   input  logic [WORD_SIZE-1:0]  upd_pc,
   input  logic [INDEX_BITS-1:0] upd_index,
   input  logic                  upd_taken,
   input  logic [WORD_SIZE-1:0]  upd_target,
   input  logic                  upd_mispredict,
   output logic [WORD_SIZE-1:0]  num_branch,
   output logic [WORD_SIZE-1:0]  num_mispredict
);

   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;

   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [CTR_BITS-1:0] CTR_WT   = CTR_BITS'(1) << (CTR_BITS - 1);
   localparam logic [CTR_BITS-1:0] CTR_WNT  = CTR_WT - CTR_BITS'(1);
   localparam logic [WORD_SIZE-1:0] SAT_MAX = '1;

   logic                 valid_q  [ENTRIES];
   logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
   logic [WORD_SIZE-1:0] target_q [ENTRIES];
   logic [CTR_BITS-1:0]  ctr_q    [ENTRIES];

   logic [INDEX_BITS-1:0] hist_ext;
   logic                  fetch_hit;
   logic                  upd_en;
   logic                  upd_hit;
   logic                  upd_write;
   logic                  upd_alloc;
   logic [CTR_BITS-1:0]   ctr_new;

   // Low PC bits select the entry on the update side; only the tag half is compared.
   logic unused_upd_pc_bits;
   assign unused_upd_pc_bits = ^upd_pc[INDEX_BITS-1:0];

   assign upd_en = upd_valid && !Stall;

   // Global history exists only in gshare mode; bimodal indexes with plain PC bits.
   generate
      if (HIST_BITS > 0) begin : g_ghr
         logic [HIST_BITS-1:0] ghr_q;

         // Non-speculative history: shift in resolved outcome of conditional branches.
         always_ff @(posedge Clk) begin
            if (!Reset_N)
               ghr_q <= '0;
            else if (upd_en && upd_is_cond)
               ghr_q <= HIST_BITS'({ghr_q, upd_taken});
         end

         assign hist_ext = INDEX_BITS'(ghr_q);
      end else begin : g_no_ghr
         assign hist_ext = '0;
      end
   endgenerate

   // Fetch-side lookup: reads pre-update contents, no bypass from the update port.
   always_comb begin
      pred_index = IF_PC[INDEX_BITS-1:0] ^ hist_ext;
      fetch_hit  = valid_q[pred_index] &&
                   (tag_q[pred_index] == IF_PC[WORD_SIZE-1:INDEX_BITS]);
      pred_taken = fetch_hit && ctr_q[pred_index][CTR_BITS-1];
      pred_next  = pred_taken ? target_q[pred_index] : IF_PC + WORD_SIZE'(1);
   end

   // Update decision: counter training on hit, allocation on a taken miss.
   always_comb begin
      upd_hit   = valid_q[upd_index] &&
                  (tag_q[upd_index] == upd_pc[WORD_SIZE-1:INDEX_BITS]);
      upd_write = 1'b0;
      upd_alloc = 1'b0;
      ctr_new   = ctr_q[upd_index];
      if (upd_hit) begin
         upd_write = 1'b1;
         if (!upd_is_cond)
            ctr_new = CTR_MAX;
         else if (upd_taken && ctr_q[upd_index] != CTR_MAX)
            ctr_new = ctr_q[upd_index] + CTR_BITS'(1);
         else if (!upd_taken && ctr_q[upd_index] != '0)
            ctr_new = ctr_q[upd_index] - CTR_BITS'(1);
      end else if (upd_taken) begin
         upd_write = 1'b1;
         upd_alloc = 1'b1;
         ctr_new   = upd_is_cond ? CTR_WT : CTR_MAX;
      end
   end

   // Valid bits and counters: reset to invalid / weakly not-taken.
   always_ff @(posedge Clk) begin
      if (!Reset_N) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= CTR_WNT;
         end
      end else if (upd_en && upd_write) begin
         valid_q[upd_index] <= 1'b1;
         ctr_q[upd_index]   <= ctr_new;
      end
   end

   // Tag and target payload carry no reset; guarded by the valid bit.
   always_ff @(posedge Clk) begin
      if (Reset_N && upd_en) begin
         if (upd_taken)
            target_q[upd_index] <= upd_target;
         if (upd_alloc)
            tag_q[upd_index] <= upd_pc[WORD_SIZE-1:INDEX_BITS];
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge Clk) begin
      if (!Reset_N) begin
         num_branch     <= '0;
         num_mispredict <= '0;
      end else if (upd_en) begin
         if (upd_is_cond && num_branch != SAT_MAX)
            num_branch <= num_branch + WORD_SIZE'(1);
         if (upd_mispredict && num_mispredict != SAT_MAX)
            num_mispredict <= num_mispredict + WORD_SIZE'(1);
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a bimodal instance and a gshare
// (HIST_BITS=2) instance share one stimulus stream.
module tb_branch_predictor;

   logic        Clk = 1'b0;
   logic        Reset_N;
   logic        Stall;
   logic [15:0] IF_PC;
   logic        upd_valid;
   logic        upd_is_cond;
   logic [15:0] upd_pc;
   logic [3:0]  upd_index;
   logic        upd_taken;
   logic [15:0] upd_target;
   logic        upd_mispredict;

   logic        b_taken,  g_taken;
   logic [15:0] b_next,   g_next;
   logic [3:0]  b_index,  g_index;
   logic [15:0] b_nbr,    g_nbr;
   logic [15:0] b_nmis,   g_nmis;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   branch_predictor #(.WORD_SIZE(16), .INDEX_BITS(4), .CTR_BITS(2), .HIST_BITS(0)) u_bim (
      .Clk(Clk), .Reset_N(Reset_N), .Stall(Stall), .IF_PC(IF_PC),
      .pred_taken(b_taken), .pred_next(b_next), .pred_index(b_index),
      .upd_valid(upd_valid), .upd_is_cond(upd_is_cond), .upd_pc(upd_pc),
      .upd_index(upd_index), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_mispredict(upd_mispredict), .num_branch(b_nbr), .num_mispredict(b_nmis)
   );

   branch_predictor #(.WORD_SIZE(16), .INDEX_BITS(4), .CTR_BITS(2), .HIST_BITS(2)) u_gsh (
      .Clk(Clk), .Reset_N(Reset_N), .Stall(Stall), .IF_PC(IF_PC),
      .pred_taken(g_taken), .pred_next(g_next), .pred_index(g_index),
      .upd_valid(upd_valid), .upd_is_cond(upd_is_cond), .upd_pc(upd_pc),
      .upd_index(upd_index), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_mispredict(upd_mispredict), .num_branch(g_nbr), .num_mispredict(g_nmis)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic probe(input logic [15:0] pc);
      IF_PC = pc;
      #1;
   endtask

   task automatic drive_upd(input logic cond, input logic [15:0] pc, input logic taken,
                            input logic [15:0] tgt, input logic misp);
      upd_valid      = 1'b1;
      upd_is_cond    = cond;
      upd_pc         = pc;
      upd_index      = pc[3:0];
      upd_taken      = taken;
      upd_target     = tgt;
      upd_mispredict = misp;
   endtask

   task automatic do_upd(input logic cond, input logic [15:0] pc, input logic taken,
                         input logic [15:0] tgt, input logic misp);
      drive_upd(cond, pc, taken, tgt, misp);
      tick();
      upd_valid = 1'b0;
   endtask

   initial begin
      Reset_N = 1'b0; Stall = 1'b0; IF_PC = '0;
      upd_valid = 1'b0; upd_is_cond = 1'b0; upd_pc = '0; upd_index = '0;
      upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
      tick(); tick();
      Reset_N = 1'b1;

      // Reset state
      probe(16'h0010);
      chk("rst_taken", b_taken, 0);
      chk("rst_next",  b_next, 16'h0011);
      chk("rst_index", b_index, 4'h0);
      chk("rst_nbr",   b_nbr, 0);
      chk("rst_nmis",  b_nmis, 0);

      // First taken update; same-cycle fetch sees old contents
      drive_upd(1'b1, 16'h0013, 1'b1, 16'h0020, 1'b1);
      probe(16'h0013);
      chk("nobypass_taken", b_taken, 0);
      tick(); upd_valid = 1'b0;
      probe(16'h0013);
      chk("alloc_taken", b_taken, 1);
      chk("alloc_next",  b_next, 16'h0020);
      chk("alloc_nbr",   b_nbr, 1);
      chk("alloc_nmis",  b_nmis, 1);

      // Not-taken: 10 -> 01
      do_upd(1'b1, 16'h0013, 1'b0, 16'h0000, 1'b1);
      probe(16'h0013);
      chk("weak_nt_taken", b_taken, 0);
      chk("weak_nt_next",  b_next, 16'h0014);
      chk("weak_nt_nmis",  b_nmis, 2);

      // Aliasing: same index, different tag
      probe(16'h0023);
      chk("alias_taken", b_taken, 0);
      chk("alias_next",  b_next, 16'h0024);
      chk("alias_index", b_index, 4'h3);

      // Saturation: 01 -> 10 -> 11 -> 11, then 10 (taken), then 01 (not taken)
      do_upd(1'b1, 16'h0013, 1'b1, 16'h0020, 1'b0);
      do_upd(1'b1, 16'h0013, 1'b1, 16'h0020, 1'b0);
      do_upd(1'b1, 16'h0013, 1'b1, 16'h0020, 1'b0);
      do_upd(1'b1, 16'h0013, 1'b0, 16'h0000, 1'b0);
      probe(16'h0013);
      chk("sat_10_taken", b_taken, 1);
      chk("sat_10_next",  b_next, 16'h0020);
      chk("sat_nbr",      b_nbr, 6);
      do_upd(1'b1, 16'h0013, 1'b0, 16'h0000, 1'b0);
      probe(16'h0013);
      chk("sat_01_taken", b_taken, 0);

      // Unconditional jump allocates strong-taken
      do_upd(1'b0, 16'h0005, 1'b1, 16'h0040, 1'b1);
      probe(16'h0005);
      chk("jmp_taken", b_taken, 1);
      chk("jmp_next",  b_next, 16'h0040);
      chk("jmp_nbr",   b_nbr, 7);
      chk("jmp_nmis",  b_nmis, 3);
      do_upd(1'b1, 16'h0005, 1'b0, 16'h0000, 1'b0);
      probe(16'h0005);
      chk("jmp_11_to_10", b_taken, 1);

      // Not-taken miss leaves table alone
      do_upd(1'b1, 16'h0007, 1'b0, 16'h0000, 1'b0);
      probe(16'h0007);
      chk("nt_miss_taken", b_taken, 0);
      chk("nt_miss_next",  b_next, 16'h0008);
      chk("nt_miss_nbr",   b_nbr, 9);

      // Stall for 3 cycles with a pending update
      Stall = 1'b1;
      drive_upd(1'b1, 16'h000A, 1'b1, 16'h0055, 1'b1);
      tick(); tick(); tick();
      probe(16'h000A);
      chk("stall_nbr",   b_nbr, 9);
      chk("stall_nmis",  b_nmis, 3);
      chk("stall_taken", b_taken, 0);
      Stall = 1'b0;
      tick(); upd_valid = 1'b0;
      probe(16'h000A);
      chk("unstall_nbr",   b_nbr, 10);
      chk("unstall_nmis",  b_nmis, 4);
      chk("unstall_taken", b_taken, 1);
      chk("unstall_next",  b_next, 16'h0055);

      // Fall-through wraps
      probe(16'hFFFF);
      chk("wrap_next", b_next, 16'h0000);

      // Reset wins over a concurrent update
      drive_upd(1'b1, 16'h0007, 1'b1, 16'h0077, 1'b1);
      Reset_N = 1'b0;
      tick();
      Reset_N = 1'b1; upd_valid = 1'b0;
      probe(16'h0013);
      chk("midrst_nbr",    b_nbr, 0);
      chk("midrst_nmis",   b_nmis, 0);
      chk("midrst_taken",  b_taken, 0);
      chk("midrst_next",   b_next, 16'h0014);
      probe(16'h0007);
      chk("midrst_prio",   b_taken, 0);

      // gshare: two taken conditional updates leave GHR=11
      do_upd(1'b1, 16'h0013, 1'b1, 16'h0020, 1'b1);
      do_upd(1'b1, 16'h0013, 1'b1, 16'h0020, 1'b1);
      probe(16'h0010);
      chk("gs_index",     g_index, 4'h3);
      chk("gs_taken",     g_taken, 1);
      chk("gs_next",      g_next, 16'h0020);
      chk("gs_nmis",      g_nmis, 2);
      chk("bim_index",    b_index, 4'h0);
      probe(16'h0013);
      chk("gs13_index",   g_index, 4'h0);
      chk("gs13_taken",   g_taken, 0);

      // gshare reset mid-run clears history and stats
      Reset_N = 1'b0;
      tick();
      Reset_N = 1'b1;
      probe(16'h0010);
      chk("gs_rst_index", g_index, 4'h0);
      chk("gs_rst_taken", g_taken, 0);
      chk("gs_rst_next",  g_next, 16'h0011);
      chk("gs_rst_nmis",  g_nmis, 0);
      chk("gs_rst_nbr",   g_nbr, 0);
      probe(16'h0013);
      chk("gs_rst13_taken", g_taken, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
